seq_divider: RTL and testbench



---
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Divide handshake between the execute stage (master) and the iterative divider (slave).
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result packed as {remainder, quotient}, held until the requester drops start.
module seq_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [WIDTH-1:0]   r_dvd, w_dvd_nx;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nx;
    logic [WIDTH-1:0]   r_rem, w_rem_nx;
    logic               r_sign1, w_sign1_nx;
    logic               r_sign2, w_sign2_nx;
    logic               r_signed, w_signed_nx;
    logic               r_ready, w_ready_nx;
    logic [2*WIDTH-1:0] r_result, w_result_nx;

    logic [WIDTH-1:0]   w_abs1, w_abs2;
    logic [WIDTH:0]     w_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_quo, w_rmd;

    assign bus.ready_o  = r_ready;
    assign bus.result_o = r_result;

    // Magnitudes of the operands; the sign bits are kept separately for fix-up.
    assign w_abs1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? WIDTH'(0) - bus.opdata1_i : bus.opdata1_i;
    assign w_abs2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? WIDTH'(0) - bus.opdata2_i : bus.opdata2_i;

    // Trial subtraction on the shifted partial remainder; the wrapped difference
    // is exact whenever no borrow occurs because the true result is below the divisor.
    assign w_sh   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge   = (w_sh >= {1'b0, r_dvs});
    assign w_diff = w_sh[WIDTH-1:0] - r_dvs;

    assign w_quo = (r_signed && (r_sign1 ^ r_sign2)) ? WIDTH'(0) - r_dvd : r_dvd;
    assign w_rmd = (r_signed && r_sign1) ? WIDTH'(0) - r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_signed <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_dvd    <= w_dvd_nx;
            r_dvs    <= w_dvs_nx;
            r_rem    <= w_rem_nx;
            r_sign1  <= w_sign1_nx;
            r_sign2  <= w_sign2_nx;
            r_signed <= w_signed_nx;
            r_ready  <= w_ready_nx;
            r_result <= w_result_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_dvd_nx    = r_dvd;
        w_dvs_nx    = r_dvs;
        w_rem_nx    = r_rem;
        w_sign1_nx  = r_sign1;
        w_sign2_nx  = r_sign2;
        w_signed_nx = r_signed;
        w_ready_nx  = 1'b0;
        w_result_nx = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    w_signed_nx = bus.signed_div_i;
                    w_sign1_nx  = bus.opdata1_i[WIDTH-1];
                    w_sign2_nx  = bus.opdata2_i[WIDTH-1];
                    w_dvs_nx    = w_abs2;
                    w_rem_nx    = '0;
                    w_cnt_nx    = '0;
                    // A zero divisor clears the datapath so fix-up yields zero.
                    if (bus.opdata2_i == '0) begin
                        w_dvd_nx   = '0;
                        w_state_nx = S_BYZERO;
                    end else begin
                        w_dvd_nx   = w_abs1;
                        w_state_nx = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                w_state_nx = S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_rem_nx = w_ge ? w_diff : w_sh[WIDTH-1:0];
                    w_dvd_nx = {r_dvd[WIDTH-2:0], w_ge};
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_nx = S_END;
                    end
                end
            end
            S_END: begin
                if (bus.start_i) begin
                    w_ready_nx  = 1'b1;
                    w_result_nx = {w_rmd, w_quo};
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, abort/reset/operand
// corner sequences, and random operations against an arithmetic reference.
module tb_seq_divider;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[9];

    // Reference: C-style truncating division, zero divisor gives zero, overflow wraps.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    // Starts at the acceptance edge; chg>0 corrupts the dividend input after that many edges.
    task automatic wait_result(input string nm, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input int chg);
        int n;
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        @(posedge clk); #1;
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == chg) bus.opdata1_i = ~a;
            if (bus.ready_o) begin
                n = k;
                break;
            end
        end
        check({nm, " latency"}, 64'(n), 64'(lat));
        check({nm, " result"}, bus.result_o, exp);
        @(posedge clk); #1;
        check({nm, " ready hold"}, 64'(bus.ready_o), 64'd1);
        check({nm, " result hold"}, bus.result_o, exp);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check({nm, " ready drop"}, 64'(bus.ready_o), 64'd0);
        check({nm, " result clear"}, bus.result_o, 64'd0);
    endtask

    task automatic do_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int chg);
        drive(sgn, a, b);
        wait_result(nm, a, b, exp, chg);
    endtask

    initial begin
        logic        seen;
        logic        rs;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
        tbl[3] = '{1'b0, 32'd1234,       32'd0,          64'h0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};
        tbl[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000};
        tbl[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E};
        tbl[8] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          64'h0};

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            do_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
        end

        // Abort after ten iterations: no result may ever appear.
        drive(1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | bus.ready_o;
        end
        check("annul no ready", 64'(seen), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        do_op("after annul", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);

        // Reset asserted between edges at iteration 15.
        drive(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid-op ready", 64'(bus.ready_o), 64'd0);
        check("rst mid-op result", bus.result_o, 64'd0);

        // Reset while a result is being presented must clear it without an edge.
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        drive(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.ready_o;
        end
        check("pre-rst ready", 64'(seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst ready", 64'(bus.ready_o), 64'd0);
        check("async rst result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_result("post rst", 32'd100, 32'd7, 64'h00000002_0000000E, 0);

        do_op("ovf chg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 5);
        do_op("udiv chg", 1'b0, 32'd1000, 32'd9, {32'd1, 32'd111}, 20);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
            else rb = $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 300));
            do_op($sformatf("rnd%0d", i), rs, ra, rb, ref_div(rs, ra, rb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
